rr_decoder_arbiter: RTL and testbench

Round-robin arbiter that shares one 2-to-4 decoder between four requesters.
It drives the decoder's address0/address1/enable inputs and a matching one-hot grant vector.
It enforces a bounded tenure per grant and a one-cycle dead gap between grants, so there is never overlapping decoder output.
It sits directly upstream of the structural decoder, with its outputs wired straight to the decoder inputs.

---
 rtl/rr_decoder_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rr_decoder_arbiter
//
// Round-robin arbiter that shares one 2-to-4 decoder between four requesters.
// Each grant has a bounded tenure of MAX_HOLD cycles. Every grant is followed by
// a one-cycle dead gap, so two decoder outputs are never active back to back.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   reset     in   1  synchronous, active-high reset
//   request   in   4  request[i] high = requester i wants the decoder
//   address0  out  1  decoder address LSB (owner[0])
//   address1  out  1  decoder address MSB (owner[1])
//   enable    out  1  decoder enable, high only while a grant is active
//   grant     out  4  one-hot owner, 0000 when enable is low
//   busy      out  1  same as enable
//   timeout   out  1  one-cycle pulse in the gap after a MAX_HOLD forced release
//
// All outputs are registered; there is no combinational path from request.
// -----------------------------------------------------------------------------
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8,  // legal range 1..2**CNT_W
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] request,
  output logic       address0,
  output logic       address1,
  output logic       enable,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Last count value of a tenure; count runs 0..LAST so it never wraps.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [1:0]       owner, owner_n;
  logic [CNT_W-1:0] count, count_n;
  logic             timeout_n;

  // First asserted request scanning start, start+1, ... (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    count_n   = count;
    timeout_n = 1'b0;

    unique case (state)
      IDLE, GAP: begin
        if (|request) begin
          owner_n = pick(request, ptr);
          count_n = '0;
          state_n = GRANT;
        end else begin
          state_n = IDLE;
        end
      end

      GRANT: begin
        // A voluntary drop wins over the tenure limit on the same edge.
        if (!request[owner]) begin
          state_n = GAP;
          ptr_n   = owner + 2'd1;
        end else if (count == LAST) begin
          state_n   = GAP;
          ptr_n     = owner + 2'd1;
          timeout_n = 1'b1;
        end else begin
          count_n = count + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values, so they line up with the
  // state they describe in the cycle after the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state    <= IDLE;
      ptr      <= 2'd0;
      owner    <= 2'd0;
      count    <= '0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      address0 <= 1'b0;
      address1 <= 1'b0;
      grant    <= 4'b0000;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      count    <= count_n;
      enable   <= (state_n == GRANT);
      busy     <= (state_n == GRANT);
      // Address follows owner, which holds its value outside GRANT.
      address0 <= owner_n[0];
      address1 <= owner_n[1];
      grant    <= (state_n == GRANT) ? (4'b0001 << owner_n) : 4'b0000;
      timeout  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rr_decoder_arbiter
//
// Three arbiter instances (MAX_HOLD = 8, 4, 1) on a shared clock and reset,
// each with its own request vector. Inputs are driven and outputs sampled 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_rr_decoder_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0] req8, req4, req1;
  logic       a0_8, a1_8, en_8, busy_8, to_8;
  logic       a0_4, a1_4, en_4, busy_4, to_4;
  logic       a0_1, a1_1, en_1, busy_1, to_1;
  logic [3:0] gr_8, gr_4, gr_1;

  rr_decoder_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u8 (
    .clk(clk), .reset(reset), .request(req8),
    .address0(a0_8), .address1(a1_8), .enable(en_8),
    .grant(gr_8), .busy(busy_8), .timeout(to_8)
  );

  rr_decoder_arbiter #(.MAX_HOLD(4), .CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .request(req4),
    .address0(a0_4), .address1(a1_4), .enable(en_4),
    .grant(gr_4), .busy(busy_4), .timeout(to_4)
  );

  rr_decoder_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .request(req1),
    .address0(a0_1), .address1(a1_1), .enable(en_1),
    .grant(gr_1), .busy(busy_1), .timeout(to_1)
  );

  // One vector: request applied before an edge, outputs expected after it.
  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] addr;
    logic       to;
  } vec_t;

  int passed = 0;
  int total  = 0;

  function automatic vec_t v(input logic [3:0] req, input logic [3:0] grant,
                             input logic [1:0] addr, input logic to);
    vec_t r;
    r.req   = req;
    r.grant = grant;
    r.addr  = addr;
    r.to    = to;
    return r;
  endfunction

  // Packed {timeout, busy, enable, address1, address0, grant}.
  function automatic logic [8:0] actual(input int sel);
    case (sel)
      8:       return {to_8, busy_8, en_8, a1_8, a0_8, gr_8};
      4:       return {to_4, busy_4, en_4, a1_4, a0_4, gr_4};
      default: return {to_1, busy_1, en_1, a1_1, a0_1, gr_1};
    endcase
  endfunction

  function automatic logic [8:0] expected(input vec_t t);
    logic en;
    en = |t.grant;
    return {t.to, en, en, t.addr, t.grant};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got {to,busy,en,a1,a0,grant}=%b required %b", name, act, exp);
  endtask

  task automatic apply(input int sel, input vec_t t, input string name);
    case (sel)
      8:       req8 = t.req;
      4:       req4 = t.req;
      default: req1 = t.req;
    endcase
    @(posedge clk);
    #1;
    check(name, actual(sel), expected(t));
  endtask

  vec_t       tbl[$];
  logic [3:0] one_hot;

  initial begin
    // Single requester then round-robin wrap, for the MAX_HOLD=8 instance
    // starting from IDLE with ptr=0.
    tbl.push_back(v(4'b0100, 4'b0100, 2'b10, 1'b0)); // owner 2, count 0
    tbl.push_back(v(4'b0100, 4'b0100, 2'b10, 1'b0)); // count 1
    tbl.push_back(v(4'b0100, 4'b0100, 2'b10, 1'b0)); // count 2 (3rd cycle)
    tbl.push_back(v(4'b0000, 4'b0000, 2'b10, 1'b0)); // GAP, addr held, ptr=3
    tbl.push_back(v(4'b0000, 4'b0000, 2'b10, 1'b0)); // IDLE
    tbl.push_back(v(4'b1000, 4'b1000, 2'b11, 1'b0)); // owner 3
    tbl.push_back(v(4'b0000, 4'b0000, 2'b11, 1'b0)); // GAP, ptr wraps to 0
    tbl.push_back(v(4'b1001, 4'b0001, 2'b00, 1'b0)); // ptr=0 -> owner 0
    tbl.push_back(v(4'b1001, 4'b0001, 2'b00, 1'b0)); // non-owner 3 ignored
    tbl.push_back(v(4'b1000, 4'b0000, 2'b00, 1'b0)); // owner 0 drops, ptr=1
    tbl.push_back(v(4'b1001, 4'b1000, 2'b11, 1'b0)); // scan 1,2,3 -> owner 3
    tbl.push_back(v(4'b0000, 4'b0000, 2'b11, 1'b0)); // GAP, ptr=0
    tbl.push_back(v(4'b0000, 4'b0000, 2'b11, 1'b0)); // IDLE

    req8  = 4'b0000;
    req4  = 4'b0000;
    req1  = 4'b0000;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_u8", actual(8), 9'b0);
    check("reset_u4", actual(4), 9'b0);
    check("reset_u1", actual(1), 9'b0);
    reset = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) apply(8, v(4'b0000, 4'b0000, 2'b00, 1'b0), "idle");

    foreach (tbl[i]) apply(8, tbl[i], $sformatf("table[%0d]", i));

    // Saturation: ptr=0, all four requesting; 8-cycle tenures, timeout in gaps.
    for (int g = 0; g < 5; g++) begin
      one_hot = 4'b0001 << (g % 4);
      for (int c = 0; c < 8; c++)
        apply(8, v(4'b1111, one_hot, 2'(g % 4), 1'b0), $sformatf("sat_g%0d_c%0d", g, c));
      apply(8, v(4'b1111, 4'b0000, 2'(g % 4), 1'b1), $sformatf("sat_gap%0d", g));
    end
    apply(8, v(4'b0000, 4'b0000, 2'b00, 1'b0), "sat_idle"); // ptr now 1

    // Reset during cycle 4 of owner 2's tenure.
    for (int c = 0; c < 4; c++)
      apply(8, v(4'b0100, 4'b0100, 2'b10, 1'b0), $sformatf("pre_reset_c%0d", c));
    reset = 1'b1;
    apply(8, v(4'b1111, 4'b0000, 2'b00, 1'b0), "reset_mid_grant");
    reset = 1'b0;
    apply(8, v(4'b1111, 4'b0001, 2'b00, 1'b0), "first_after_reset");
    apply(8, v(4'b0000, 4'b0000, 2'b00, 1'b0), "post_reset_gap");

    // MAX_HOLD=4: drop on the edge where count=3 -> plain release.
    for (int c = 0; c < 4; c++)
      apply(4, v(4'b0001, 4'b0001, 2'b00, 1'b0), $sformatf("tie_drop_c%0d", c));
    apply(4, v(4'b0000, 4'b0000, 2'b00, 1'b0), "tie_drop_gap");
    apply(4, v(4'b0000, 4'b0000, 2'b00, 1'b0), "tie_drop_idle");
    // Held through count=3 -> forced release, ptr=1 so owner 1.
    for (int c = 0; c < 4; c++)
      apply(4, v(4'b0010, 4'b0010, 2'b01, 1'b0), $sformatf("tie_hold_c%0d", c));
    apply(4, v(4'b0010, 4'b0000, 2'b01, 1'b1), "tie_hold_gap");
    apply(4, v(4'b0000, 4'b0000, 2'b01, 1'b0), "tie_hold_idle");

    // MAX_HOLD=1: single-cycle grants, timeout whenever still requested.
    apply(1, v(4'b0011, 4'b0001, 2'b00, 1'b0), "mh1_g0");
    apply(1, v(4'b0011, 4'b0000, 2'b00, 1'b1), "mh1_gap0");
    apply(1, v(4'b0011, 4'b0010, 2'b01, 1'b0), "mh1_g1");
    apply(1, v(4'b0011, 4'b0000, 2'b01, 1'b1), "mh1_gap1");
    apply(1, v(4'b0011, 4'b0001, 2'b00, 1'b0), "mh1_g2");
    apply(1, v(4'b0000, 4'b0000, 2'b00, 1'b0), "mh1_drop_gap");
    apply(1, v(4'b0000, 4'b0000, 2'b00, 1'b0), "mh1_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
